// File: rtl/bus_xcvr_ctl.sv
// Bus transceiver controller: arbitrates A->B / B->A requests and sequences DIR, OE_n, capture clocks and selects.
// Optional macro BUS_XCVR_CTL_STATUS_EN adds the 8-bit XFER_CNT completed-transfer counter.
module bus_xcvr_ctl #(
    parameter int HOLD = 2
) (
    input  logic       sysclk,
    input  logic       sys_rst,
    input  logic       REQ_AB,
    input  logic       REQ_BA,
    input  logic       LIVE,
    output logic       GNT_AB,
    output logic       GNT_BA,
    output logic       DONE,
    output logic       BUSY,
    output logic       DIR,
    output logic       OE_n,
    output logic       CLKAB,
    output logic       CLKBA,
    output logic       SAB,
    output logic       SBA
`ifdef BUS_XCVR_CTL_STATUS_EN
    ,
    output logic [7:0] XFER_CNT
`endif
);

    localparam logic [3:0] HOLD_EFF  = (HOLD < 1) ? 4'd1 : 4'(HOLD);
    localparam logic [3:0] HOLD_LAST = HOLD_EFF - 4'd1;

    typedef enum logic [2:0] {IDLE, SETUP, CAPT, DRIVE, TURN} stateType;

    stateType   state;
    logic [3:0] holdCnt;
    logic       liveXfer;
    logic       favorBa;
    logic       pickBa;

    // Round-robin: BA wins alone, or on a tie when AB was served last.
    assign pickBa = REQ_BA && (!REQ_AB || favorBa);

    // Every output is written here alongside the state it belongs to, so each is a flop.
    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            state    <= IDLE;
            holdCnt  <= 4'd0;
            liveXfer <= 1'b0;
            favorBa  <= 1'b0;
            GNT_AB   <= 1'b0;
            GNT_BA   <= 1'b0;
            DONE     <= 1'b0;
            BUSY     <= 1'b0;
            DIR      <= 1'b0;
            OE_n     <= 1'b1;
            CLKAB    <= 1'b0;
            CLKBA    <= 1'b0;
            SAB      <= 1'b0;
            SBA      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every read in this block on the pre-edge value.
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (REQ_AB || REQ_BA) begin
                        state    <= SETUP;
                        BUSY     <= 1'b1;
                        GNT_AB   <= !pickBa;
                        GNT_BA   <= pickBa;
                        DIR      <= !pickBa;
                        liveXfer <= LIVE;
                        SAB      <= !pickBa && !LIVE;
                        SBA      <= pickBa && !LIVE;
                        favorBa  <= !pickBa;
                    end
                end
                SETUP: begin
                    if (liveXfer) begin
                        state   <= DRIVE;
                        OE_n    <= 1'b0;
                        holdCnt <= HOLD_LAST;
                        DONE    <= (HOLD_EFF == 4'd1);
                    end else begin
                        state <= CAPT;
                        CLKAB <= DIR;
                        CLKBA <= !DIR;
                    end
                end
                CAPT: begin
                    state   <= DRIVE;
                    CLKAB   <= 1'b0;
                    CLKBA   <= 1'b0;
                    OE_n    <= 1'b0;
                    holdCnt <= HOLD_LAST;
                    DONE    <= (HOLD_EFF == 4'd1);
                end
                DRIVE: begin
                    if (holdCnt == 4'd0) begin
                        state  <= TURN;
                        OE_n   <= 1'b1;
                        GNT_AB <= 1'b0;
                        GNT_BA <= 1'b0;
                    end else begin
                        holdCnt <= holdCnt - 4'd1;
                        DONE    <= (holdCnt == 4'd1);
                    end
                end
                TURN: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    SAB   <= 1'b0;
                    SBA   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BUS_XCVR_CTL_STATUS_EN
    always_ff @(posedge sysclk) begin
        if (sys_rst)
            XFER_CNT <= 8'd0;
        else if (DONE)
            XFER_CNT <= XFER_CNT + 8'd1;
    end
`endif

endmodule

// File: tb/tb_bus_xcvr_ctl.sv
// Self-checking bench for bus_xcvr_ctl: directed scenarios then random traffic against a transfer-level model.
// Define BUS_XCVR_CTL_STATUS_EN for both files to exercise XFER_CNT.
module tb_bus_xcvr_ctl;

    localparam int HOLD = 2;
    localparam int H    = (HOLD < 1) ? 1 : HOLD;

    logic sysclk  = 1'b0;
    logic sys_rst = 1'b1;
    logic REQ_AB  = 1'b0;
    logic REQ_BA  = 1'b0;
    logic LIVE    = 1'b0;
    logic GNT_AB, GNT_BA, DONE, BUSY, DIR, OE_n, CLKAB, CLKBA, SAB, SBA;
`ifdef BUS_XCVR_CTL_STATUS_EN
    logic [7:0] XFER_CNT;
`endif

    int errors = 0;
    int checks = 0;

    // Transfer-level model: a transfer is a start cycle, a side and a mode; outputs follow from the offset.
    int  cyc      = 0;
    bit  mActive  = 1'b0;
    bit  mSideBa  = 1'b0;
    bit  mLive    = 1'b0;
    bit  mDir     = 1'b0;
    bit  mFavorBa = 1'b0;
    int  mStart   = 0;
    int  mCnt     = 0;

    bus_xcvr_ctl #(.HOLD(HOLD)) dut (
        .sysclk  (sysclk),
        .sys_rst (sys_rst),
        .REQ_AB  (REQ_AB),
        .REQ_BA  (REQ_BA),
        .LIVE    (LIVE),
        .GNT_AB  (GNT_AB),
        .GNT_BA  (GNT_BA),
        .DONE    (DONE),
        .BUSY    (BUSY),
        .DIR     (DIR),
        .OE_n    (OE_n),
        .CLKAB   (CLKAB),
        .CLKBA   (CLKBA),
        .SAB     (SAB),
        .SBA     (SBA)
`ifdef BUS_XCVR_CTL_STATUS_EN
        ,
        .XFER_CNT(XFER_CNT)
`endif
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic checkByte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare every output.
    task automatic step();
        bit ra, rb, lv, rs, pick;
        int k, c;
        bit eGnt, eBusy, eOe, eDone, eClk;
        ra = REQ_AB;
        rb = REQ_BA;
        lv = LIVE;
        rs = sys_rst;
        @(posedge sysclk);
        if (rs) begin
            mActive  = 1'b0;
            mDir     = 1'b0;
            mFavorBa = 1'b0;
            mCnt     = 0;
        end else if (mActive) begin
            k = cyc - mStart;
            c = mLive ? 0 : 1;
            if (k == H + c)
                mCnt = (mCnt + 1) % 256;
            if (k == H + c + 1)
                mActive = 1'b0;
        end else if (ra || rb) begin
            pick     = rb && (!ra || mFavorBa);
            mSideBa  = pick;
            mFavorBa = !pick;
            mDir     = !pick;
            mLive    = lv;
            mStart   = cyc + 1;
            mActive  = 1'b1;
        end
        cyc++;
        #1;
        eGnt = 1'b0; eBusy = 1'b0; eOe = 1'b1; eDone = 1'b0; eClk = 1'b0;
        if (mActive) begin
            k     = cyc - mStart;
            c     = mLive ? 0 : 1;
            eBusy = 1'b1;
            eGnt  = (k <= H + c);
            eOe   = !(k >= 1 + c && k <= H + c);
            eDone = (k == H + c);
            eClk  = !mLive && (k == 1);
        end
        check("GNT_AB", GNT_AB, eGnt && !mSideBa);
        check("GNT_BA", GNT_BA, eGnt && mSideBa);
        check("BUSY", BUSY, eBusy);
        check("OE_n", OE_n, eOe);
        check("DONE", DONE, eDone);
        check("CLKAB", CLKAB, eClk && !mSideBa);
        check("CLKBA", CLKBA, eClk && mSideBa);
        check("SAB", SAB, mActive && !mSideBa && !mLive);
        check("SBA", SBA, mActive && mSideBa && !mLive);
        check("DIR", DIR, mDir);
`ifdef BUS_XCVR_CTL_STATUS_EN
        checkByte("XFER_CNT", XFER_CNT, 8'(mCnt));
`endif
    endtask

    task automatic doReset();
        sys_rst = 1'b1;
        REQ_AB  = 1'b0;
        REQ_BA  = 1'b0;
        LIVE    = 1'b0;
        step();
        sys_rst = 1'b0;
    endtask

    initial begin
        // Reset state over two edges.
        step();
        doReset();

        // Stored AB transfer; request dropped after grant must still complete.
        REQ_AB = 1'b1;
        step();
        REQ_AB = 1'b0;
        check("r028_gnt_c1", GNT_AB, 1'b1);
        check("r028_sab_c1", SAB, 1'b1);
        step();
        check("r028_clkab_c2", CLKAB, 1'b1);
        step();
        check("r028_oe_c3", OE_n, 1'b0);
        step();
        check("r028_done_c4", DONE, 1'b1);
        check("r028_dir_c4", DIR, 1'b1);
        step();
        step();
        check("r028_idle_c6", BUSY, 1'b0);

        // Simultaneous requests after reset: AB first, BA set up at cycle 7.
        doReset();
        REQ_AB = 1'b1;
        REQ_BA = 1'b1;
        step();
        REQ_AB = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("r029_gnt_ba_c7", GNT_BA, 1'b1);
        check("r029_dir_c7", DIR, 1'b0);
        step();
        check("r029_clkba_c8", CLKBA, 1'b1);
        REQ_BA = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // Live BA transfer: one cycle shorter, no capture clock.
        doReset();
        REQ_BA = 1'b1;
        LIVE   = 1'b1;
        step();
        REQ_BA = 1'b0;
        LIVE   = 1'b0;
        check("r030_sba_c1", SBA, 1'b0);
        step();
        check("r030_oe_c2", OE_n, 1'b0);
        check("r030_noclk_c2", CLKBA, 1'b0);
        step();
        check("r030_done_c3", DONE, 1'b1);
        for (int i = 0; i < 3; i++) step();
        check("r030_idle_c6", BUSY, 1'b0);

        // Both requests held: alternating grants with turnaround between.
        doReset();
        REQ_AB = 1'b1;
        REQ_BA = 1'b1;
        for (int i = 0; i < 30; i++) step();
        REQ_AB = 1'b0;
        REQ_BA = 1'b0;
        for (int i = 0; i < 8; i++) step();

        // Reset during the first DRIVE cycle aborts without DONE.
        doReset();
        REQ_AB = 1'b1;
        step();
        REQ_AB = 1'b0;
        step();
        step();
        check("r032_in_drive", OE_n, 1'b0);
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        check("r032_oe", OE_n, 1'b1);
        check("r032_gnt", GNT_AB, 1'b0);
        check("r032_busy", BUSY, 1'b0);
        check("r032_done", DONE, 1'b0);
        for (int i = 0; i < 4; i++) step();

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            REQ_AB  = ($urandom_range(0, 3) == 0);
            REQ_BA  = ($urandom_range(0, 3) == 0);
            LIVE    = $urandom_range(0, 1) == 1;
            sys_rst = ($urandom_range(0, 99) == 0);
            step();
        end
        sys_rst = 1'b0;

`ifdef BUS_XCVR_CTL_STATUS_EN
        // 257 transfers wrap the counter to 1; reset clears it.
        begin
            int dones;
            int budget;
            dones  = 0;
            budget = 257 * (H + 4) + 50;
            doReset();
            REQ_AB = 1'b1;
            while (dones < 257 && budget > 0) begin
                step();
                if (DONE === 1'b1) dones++;
                budget--;
            end
            REQ_AB = 1'b0;
            check("r033_budget", budget > 0, 1'b1);
            for (int i = 0; i < 5; i++) step();
            checkByte("r033_wrap", XFER_CNT, 8'd1);
            doReset();
            step();
            checkByte("r033_clear", XFER_CNT, 8'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
